// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : adder_pkg
// Brief    : Shared constants, types and helpers for the pipelined adder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // Operation select on the sub input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Segment width of the default build; sizes the payload type below.
    localparam int SEG_DEFAULT = 4;

    // One stage's contribution: its slice of the result plus the carry it hands on.
    typedef struct packed {
        logic                   carry;
        logic [SEG_DEFAULT-1:0] sum;
    } seg_payload_t;

    // Number of pipeline stages; guarded so a bad SEG cannot divide by zero
    // before the configuration check in the top level reports it.
    function automatic int calc_nstage(input int width, input int seg);
        return (seg < 1) ? 1 : (width / seg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
// ============================================================================
// Module   : adder_segment
// Brief    : Combinational SEG-bit ripple of full-adder cells. Also exposes
//            the carry into the top cell so the caller can form signed
//            overflow.
// Revision : 1.0 - initial release
// ============================================================================
module adder_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_c_msb
);

    // Ripple the carry through each full-adder cell, LSB first.
    always_comb begin
        logic c_v;
        c_v     = i_cin;
        o_sum   = '0;
        o_c_msb = i_cin;
        for (int i = 0; i < SEG; i++) begin
            if (i == SEG - 1) begin
                o_c_msb = c_v;
            end
            o_sum[i] = i_a[i] ^ i_b[i] ^ c_v;
            c_v      = (i_a[i] & i_b[i]) | (c_v & (i_a[i] ^ i_b[i]));
        end
        o_cout = c_v;
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Brief    : Pipelined two's-complement adder/subtractor. One SEG-bit segment
//            of the carry chain is resolved per stage; operands and results
//            use valid/ready with whole-pipeline backpressure.
// Options  : ADDER_OVERFLOW_EN - when defined, overflow carries the registered
//            signed-overflow flag; otherwise it is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NSTAGE = calc_nstage(WIDTH, SEG);

    // Reject configurations that cannot be split into whole segments.
    if (SEG < 1) begin : g_bad_seg
        $error("pipelined_adder: SEG must be at least 1");
    end else if ((WIDTH % SEG) != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of SEG");
    end

    // Word layout per stage: processed result segments are rotated in at the
    // top while the not-yet-added operand A segments shift down, so after the
    // final stage the word is exactly the result (skew and deskew in one).
    logic [WIDTH-1:0] word_s  [NSTAGE];
    logic [WIDTH-1:0] bw_s    [NSTAGE];
    logic             carry_s [NSTAGE];
    logic             valid_s [NSTAGE];
    logic             cmsb_s  [NSTAGE];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Map the operation onto a plain addition: subtract is A + ~B + 1.
    always_comb begin
        b_eff = (sub == MODE_SUB) ? ~b : b;
        c0    = (sub == MODE_SUB) ? 1'b1 : cin;
    end

    // The whole pipeline moves together unless the output beat is stuck.
    assign adv       = !valid_s[NSTAGE-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_s[NSTAGE-1];
    assign sum       = word_s[NSTAGE-1];
    assign cout      = carry_s[NSTAGE-1];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic [WIDTH-1:0] x_in;
        logic [WIDTH-1:0] y_in;
        logic             c_in;
        logic             v_in;
        logic [SEG-1:0]   seg_sum;
        logic             seg_cout;
        logic [WIDTH-1:0] word_next;
        logic [WIDTH-1:0] word_d;
        logic [WIDTH-1:0] word_q;
        logic             carry_d;
        logic             carry_q;
        logic             valid_d;
        logic             valid_q;

        if (k == 0) begin : g_first
            assign x_in = a;
            assign y_in = b_eff;
            assign c_in = c0;
            assign v_in = in_valid;
        end else begin : g_next
            assign x_in = word_s[k-1];
            assign y_in = bw_s[k-1];
            assign c_in = carry_s[k-1];
            assign v_in = valid_s[k-1];
        end

        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .i_a     (x_in[SEG-1:0]),
            .i_b     (y_in[SEG-1:0]),
            .i_cin   (c_in),
            .o_sum   (seg_sum),
            .o_cout  (seg_cout),
`ifdef ADDER_OVERFLOW_EN
            .o_c_msb (cmsb_s[k])
`else
            .o_c_msb ()
`endif
        );

        if (NSTAGE == 1) begin : g_single
            assign word_next = seg_sum;
        end else begin : g_multi
            assign word_next = {seg_sum, x_in[WIDTH-1:SEG]};
        end

        // Load a new beat on advance; data only moves with a valid beat.
        always_comb begin
            valid_d = valid_q;
            word_d  = word_q;
            carry_d = carry_q;
            if (adv) begin
                valid_d = v_in;
                if (v_in) begin
                    word_d  = word_next;
                    carry_d = seg_cout;
                end
            end
        end

        // Stage registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                word_q  <= '0;
                carry_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                word_q  <= word_d;
                carry_q <= carry_d;
            end
        end

        assign word_s[k]  = word_q;
        assign carry_s[k] = carry_q;
        assign valid_s[k] = valid_q;

        // Remaining B segments travel alongside; the last stage needs none.
        if (k < NSTAGE - 1) begin : g_skew
            logic [WIDTH-1:0] bw_d;
            logic [WIDTH-1:0] bw_q;

            // Shift the consumed B segment out as the beat advances.
            always_comb begin
                bw_d = bw_q;
                if (adv && v_in) begin
                    bw_d = y_in >> SEG;
                end
            end

            // Skew register for operand B.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    bw_q <= '0;
                end else begin
                    bw_q <= bw_d;
                end
            end

            assign bw_s[k] = bw_q;
        end

`ifdef ADDER_OVERFLOW_EN
        if (k == NSTAGE - 1) begin : g_ovf_tap
            logic ovf_d;
            logic ovf_q;

            // Signed overflow is carry into the MSB differing from carry out.
            always_comb begin
                ovf_d = ovf_q;
                if (adv && v_in) begin
                    ovf_d = cmsb_s[k] ^ seg_cout;
                end
            end

            // Overflow flag registered with the final stage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end

            assign overflow = ovf_q;
        end
`endif
    end

`ifndef ADDER_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Brief    : Self-checking bench for pipelined_adder (16/4 and 8/8 builds).
//            Honours ADDER_OVERFLOW_EN for the expected overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

`ifdef ADDER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, overflow;

    logic       in_valid_8, in_ready_8, out_valid_8, out_ready_8;
    logic [7:0] a_8, b_8, sum_8;
    logic       cin_8, sub_8, cout_8, overflow_8;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    pipelined_adder #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a(a_8), .b(b_8), .cin(cin_8), .sub(sub_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .sum(sum_8), .cout(cout_8), .overflow(overflow_8)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on the operand values.
    function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi,
                                   input logic ci, input logic si);
        exp_t r;
        int   ua, ub, total, sa, sb, st;
        ua = int'(ai);
        ub = int'(bi);
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        if (si) begin
            total  = ua - ub;
            st     = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            total  = ua + ub + int'(ci);
            st     = sa + sb + int'(ci);
            r.cout = (total > 65535);
        end
        r.sum = total[15:0];
        r.ovf = OVF_EN && ((st > 32767) || (st < -32768));
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid_8 = 1'b0; out_ready_8 = 1'b0; a_8 = '0; b_8 = '0; cin_8 = 1'b0; sub_8 = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid_8: got %b expected 0", out_valid_8); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vc [3];
        logic        vs [3];
        logic [15:0] es [3];
        logic        ec [3];
        logic        eo [3];
        int          lat;
        va = '{16'hFFFF, 16'h0005, 16'h7FFF};
        vb = '{16'h0001, 16'h0007, 16'h0001};
        vc = '{1'b0, 1'b1, 1'b0};
        vs = '{1'b0, 1'b1, 1'b0};
        es = '{16'h0000, 16'hFFFE, 16'h8000};
        ec = '{1'b1, 1'b0, 1'b0};
        eo = '{1'b0, 1'b0, OVF_EN};
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++; if (lat !== LAT) begin errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, LAT); end
            checks++; if (sum !== es[i]) begin errors++; $display("FAIL directed%0d_sum: got %h expected %h", i, sum, es[i]); end
            checks++; if (cout !== ec[i]) begin errors++; $display("FAIL directed%0d_cout: got %b expected %b", i, cout, ec[i]); end
            checks++; if (overflow !== eo[i]) begin errors++; $display("FAIL directed%0d_overflow: got %b expected %b", i, overflow, eo[i]); end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_random_stream();
        exp_t e;
        int   cyc;
        for (cyc = 0; cyc < 80; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, (!out_valid || out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_beat: got sum %h expected no beat", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                        errors++; $display("FAIL stream_result: got %h/%b/%b expected %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 30) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                    errors++; $display("FAIL drain_result: got %h/%b/%b expected %h/%b/%b", sum, cout, overflow, e.sum, e.cout, e.ovf);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_lost_beats: got %0d outstanding expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          sent, got, cyc;
        bit          need_new, held;
        logic [15:0] held_sum;
        sent = 0; got = 0; cyc = 0; need_new = 1'b1; held = 1'b0; held_sum = '0;
        while ((sent < 8 || exp_q.size() > 0) && cyc < 60) begin
            if (need_new) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                need_new = 1'b0;
            end
            in_valid  = (sent < 8);
            out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready); end
            end
            if (held) begin
                checks++;
                if (sum !== held_sum) begin errors++; $display("FAIL stall_sum_stable: got %h expected %h", sum, held_sum); end
            end
            held     = out_valid && !out_ready;
            held_sum = sum;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_beat: got sum %h expected no beat", sum);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                        errors++; $display("FAIL bp_result%0d: got %h/%b/%b expected %h/%b/%b", got, sum, cout, overflow, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
                need_new = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got); end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            if (i == 2) begin
                reset = 1'b1;
                #1;
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
                checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midreset_sum: got %h expected 0000", sum); end
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
            end
            @(negedge clk);
        end
        reset = 1'b0;
        a = 16'h1234; b = 16'h0F0F; cin = 1'b1; sub = 1'b0;
        e = model(a, b, cin, sub);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL midreset_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (sum !== e.sum) begin errors++; $display("FAIL midreset_sum_after: got %h expected %h", sum, e.sum); end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_ghost_beat: got %b expected 0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        int         total, st;
        logic [7:0] es;
        logic       ec, eo;
        out_ready_8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                a_8 = 8'h80; b_8 = 8'h80; cin_8 = 1'b0; sub_8 = 1'b0;
            end else begin
                a_8 = 8'($urandom); b_8 = 8'($urandom); cin_8 = 1'($urandom); sub_8 = 1'($urandom);
            end
            if (sub_8) begin
                total = int'(a_8) - int'(b_8);
                st    = int'($signed(a_8)) - int'($signed(b_8));
                ec    = (a_8 >= b_8);
            end else begin
                total = int'(a_8) + int'(b_8) + int'(cin_8);
                st    = int'($signed(a_8)) + int'($signed(b_8)) + int'(cin_8);
                ec    = (total > 255);
            end
            es = total[7:0];
            eo = OVF_EN && ((st > 127) || (st < -128));
            in_valid_8 = 1'b1;
            @(posedge clk);
            #1;
            in_valid_8 = 1'b0;
            checks++; if (out_valid_8 !== 1'b1) begin errors++; $display("FAIL deg%0d_latency: got out_valid %b expected 1", i, out_valid_8); end
            checks++;
            if ({sum_8, cout_8, overflow_8} !== {es, ec, eo}) begin
                errors++; $display("FAIL deg%0d_result: got %h/%b/%b expected %h/%b/%b", i, sum_8, cout_8, overflow_8, es, ec, eo);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random_stream();
        test_backpressure();
        test_reset_midflight();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor. Replaces the fixed 4-bit combinational ripple adder in datapaths that need wider operands or higher clock rates. Carry ripples through one SEG-bit segment per pipeline stage. Operands and results move on a valid/ready handshake with full-pipeline backpressure.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage. NSTAGE = WIDTH/SEG sets the latency in cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  the operand beat is valid.
- in_ready  out  1  the block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used in add mode only.
- sub  in  1  0 selects A+B+cin; 1 selects A−B.
- out_valid  out  1  the result beat is valid.
- out_ready  in  1  the consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB.
- overflow  out  1  signed overflow flag (see Configuration).

## Operation
- Operand mapping: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin. Subtract mode ignores cin, and cout=1 means no borrow.
- Stage k (0..NSTAGE−1) adds segment k of a and b_eff plus the carry registered by stage k−1. Stage 0 uses c0.
- Each stage registers:
  - its segment sum and carry,
  - the not-yet-used upper operand segments (skew),
  - the lower result segments already computed (deskew),
  - a valid bit.
- Global advance: adv = !out_valid || out_ready. When adv=0, every stage register holds.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- Bubbles propagate as valid=0. The pipeline does not compact bubbles.
- Results leave in issue order. No beat is lost or duplicated under any stall pattern.
- Arithmetic is modulo 2^WIDTH.
- Elaboration fails if WIDTH % SEG ≠ 0 or SEG < 1.

## Timing
- Latency is NSTAGE cycles from acceptance to out_valid when out_ready stays high.
- Throughput is one beat per cycle.
- Reset values: out_valid=0, sum=0, cout=0, overflow=0, all internal valids=0. in_ready=1 while reset is asserted and after it.
- Reset asserted mid-operation discards all in-flight beats. The first accepted beat after deassertion appears NSTAGE cycles later.
- If out_valid=1 and out_ready=0, then sum, cout and overflow stay stable until the beat is taken.
- Simultaneous accept and emit in one cycle is legal and is the normal streaming case.
- sum, cout and overflow are meaningful only while out_valid=1, but they are driven from registers at all times (no X).
- NSTAGE=1 degenerates to a registered single-cycle adder with the same handshake.

## Configuration
- ADDER_OVERFLOW_EN defined:
  - overflow = carry into MSB XOR carry out of MSB, registered with the final stage.
  - It applies to both add and subtract modes.
- ADDER_OVERFLOW_EN undefined:
  - The overflow port remains but is tied to 0.
  - No MSB-carry tap logic is generated.

## Structure
- Package adder_pkg holds:
  - the mode constants (MODE_ADD=1'b0, MODE_SUB=1'b1),
  - the NSTAGE derivation function,
  - the segment-payload typedef (sum segment plus carry).
- Sub-module adder_segment: combinational SEG-bit ripple of full-adder cells. It takes a SEG-bit a, b and cin and returns a SEG-bit sum, cout and the MSB carry-in for the overflow tap. It is instantiated once per stage through a generate loop.
- The top level holds only the stage registers, skew/deskew shift registers and handshake logic.

## Test plan
All cases use WIDTH=16, SEG=4, NSTAGE=4 unless stated.
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles sum=0x0000, cout=1, overflow=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, overflow=0.
- Overflow (macro defined): a=0x7FFF, b=0x0001, add → sum=0x8000, overflow=1. With the macro undefined, overflow=0 and sum is unchanged.
- Backpressure: stream 8 random beats back-to-back and hold out_ready=0 for cycles 5–7 → in_ready=0 during the stall, all 8 results match the reference model in order, none dropped or duplicated.
- Reset mid-flight: accept 3 beats, assert reset for 1 cycle at cycle 2 → out_valid=0 and sum=0 immediately. The next beat accepted after deassertion appears exactly 4 cycles later.
- Degenerate config WIDTH=8, SEG=8: a=0x80, b=0x80, add → 1-cycle latency, sum=0x00, cout=1, overflow=1 (macro defined).
